// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: 2-bit direction counter
// encoding, saturating next-state function and default geometry.
package btb_pkg;

    localparam int unsigned ENTRIES_DEF = 16;
    localparam int unsigned XLEN_DEF    = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Saturating step toward the resolved direction; ST and SNT hold.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        end
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup and execute-side update bundle for the branch target buffer.
interface branch_target_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic [XLEN-1:0] fetch_PC;
    logic            hit;
    logic            taken;
    logic [XLEN-1:0] pred_PC;
    logic            upd_valid;
    logic [XLEN-1:0] upd_PC;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic            mispredict;

    modport master (
        output flush, fetch_PC, upd_valid, upd_PC, upd_target, upd_taken,
        input  hit, taken, pred_PC, mispredict
    );

    modport slave (
        input  flush, fetch_PC, upd_valid, upd_PC, upd_target, upd_taken,
        output hit, taken, pred_PC, mispredict
    );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// One 2-bit saturating direction counter; load forces weakly-taken on allocation.
module sat_counter2
    import btb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic load,
    input  logic taken,
    output ctr_t ctr
);
    ctr_t ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load) begin
            ctr_d = WT;
        end else if (en) begin
            ctr_d = ctr_next(ctr_q, taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr_q <= WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr = ctr_q;
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry 2-bit counters; combinational lookup, EX-driven update.
// Optional BTB_FWD_EN: forward a same-cycle update (and flush) into the lookup path.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = ENTRIES_DEF,
    parameter int unsigned XLEN    = XLEN_DEF
) (
    input logic                   clk,
    input logic                   rst,
    branch_target_buffer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    ctr_t               entry_ctr[ENTRIES];
    logic               mispredict_q, mispredict_d;

    logic [ENTRIES-1:0] cnt_en, ld_en;
    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               u_hit, u_pred_tk, wr_en;
    logic               unused_pc_lsbs;

    assign f_idx = bus.fetch_PC[IDX_W+1:2];
    assign f_tag = bus.fetch_PC[XLEN-1:IDX_W+2];
    assign u_idx = bus.upd_PC[IDX_W+1:2];
    assign u_tag = bus.upd_PC[XLEN-1:IDX_W+2];
    assign unused_pc_lsbs = ^{bus.fetch_PC[1:0], bus.upd_PC[1:0]};

    assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_pred_tk = u_hit && entry_ctr[u_idx][1];
    // A not-taken miss never allocates; flush drops any update.
    assign wr_en     = bus.upd_valid && !bus.flush && (u_hit || bus.upd_taken);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        sat_counter2 u_ctr (
            .clk   (clk),
            .rst_n (rst),
            .en    (cnt_en[i]),
            .load  (ld_en[i]),
            .taken (bus.upd_taken),
            .ctr   (entry_ctr[i])
        );
    end

    // Table next-state
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_en   = '0;
        ld_en    = '0;
        if (bus.flush) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = bus.upd_target;
            cnt_en[u_idx]   = u_hit;
            ld_en[u_idx]    = !u_hit;
        end
    end

    assign mispredict_d = bus.upd_valid &&
                          ((bus.upd_taken != u_pred_tk) ||
                           (bus.upd_taken && u_hit && (target_q[u_idx] != bus.upd_target)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            tag_q        <= '{default: '0};
            target_q     <= '{default: '0};
            mispredict_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            mispredict_q <= mispredict_d;
        end
    end

    logic             l_valid, l_kill, hit_c;
    logic [TAG_W-1:0] l_tag;
    logic [XLEN-1:0]  l_target;
    ctr_t             l_ctr;

    // Lookup mux, optionally overlaid with the in-flight update entry
    always_comb begin
        l_valid  = valid_q[f_idx];
        l_tag    = tag_q[f_idx];
        l_target = target_q[f_idx];
        l_ctr    = entry_ctr[f_idx];
        l_kill   = 1'b0;
`ifdef BTB_FWD_EN
        if (wr_en && (f_idx == u_idx)) begin
            l_valid  = 1'b1;
            l_tag    = u_tag;
            l_target = bus.upd_target;
            l_ctr    = u_hit ? ctr_next(entry_ctr[u_idx], bus.upd_taken) : WT;
        end
        l_kill = bus.flush;
`endif
        hit_c = l_valid && !l_kill && (l_tag == f_tag);
    end

    assign bus.hit        = hit_c;
    assign bus.taken      = hit_c && l_ctr[1];
    assign bus.pred_PC    = hit_c ? l_target : bus.fetch_PC + XLEN'(4);
    assign bus.mispredict = mispredict_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Table-driven bench for branch_target_buffer with a mispredict scoreboard queue.
module tb_branch_target_buffer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic exp_q[$];

    branch_target_buffer_if #(.XLEN(32)) bus ();

    branch_target_buffer #(.ENTRIES(16), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic [31:0] fpc;
        logic        ehit;
        logic        etk;
        logic [31:0] epred;
        logic        emis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic uv, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic utk, input logic [31:0] fpc,
                                input logic ehit, input logic etk, input logic [31:0] epred,
                                input logic emis);
        vec_t v;
        v.fl = fl; v.uv = uv; v.upc = upc; v.utgt = utgt; v.utk = utk;
        v.fpc = fpc; v.ehit = ehit; v.etk = etk; v.epred = epred; v.emis = emis;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Drive one row, check the 0-cycle lookup, then the registered mispredict after the edge.
    task automatic step(input vec_t v, input int idx);
        logic e;
        @(negedge clk);
        bus.flush      = v.fl;
        bus.upd_valid  = v.uv;
        bus.upd_PC     = v.upc;
        bus.upd_target = v.utgt;
        bus.upd_taken  = v.utk;
        bus.fetch_PC   = v.fpc;
        #1;
        chk("hit",     idx, 32'(bus.hit),   32'(v.ehit));
        chk("taken",   idx, 32'(bus.taken), 32'(v.etk));
        chk("pred_PC", idx, bus.pred_PC,    v.epred);
        exp_q.push_back(v.emis);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard[%0d] actual=empty required=entry", idx);
        end else begin
            e = exp_q.pop_front();
            chk("mispredict", idx, 32'(bus.mispredict), 32'(e));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b0;
        bus.flush      = 1'b0;
        bus.upd_valid  = 1'b0;
        bus.upd_PC     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        bus.fetch_PC   = 32'h100;

        #3;
        chk("rst_hit",        0, 32'(bus.hit),        32'd0);
        chk("rst_taken",      0, 32'(bus.taken),      32'd0);
        chk("rst_pred_PC",    0, bus.pred_PC,         32'h104);
        chk("rst_mispredict", 0, 32'(bus.mispredict), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //          fl  uv  upc       utgt      tk  fpc           hit tk  pred          mis
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      0, 0, 32'h104,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 1, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      1, 1, 32'h200,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 0, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 0, 32'h104,      0, 0, 32'h108,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      1, 0, 32'h200,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 0, 32'h104,      0, 0, 32'h108,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 1, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      1, 0, 32'h200,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h200, 1, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      1, 1, 32'h200,      0));
        vecs.push_back(mk(0, 1, 32'h100, 32'h250, 1, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      1, 1, 32'h250,      0));
        vecs.push_back(mk(0, 1, 32'h140, 32'h500, 1, 32'h104,      0, 0, 32'h108,      1));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      0, 0, 32'h104,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h140,      1, 1, 32'h500,      0));
        vecs.push_back(mk(0, 1, 32'h144, 32'h700, 0, 32'h104,      0, 0, 32'h108,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h144,      0, 0, 32'h148,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'hFFFFFFFC, 0, 0, 32'h0,        0));
        // flush together with an aliasing taken update: update dropped, mispredict still raised
`ifdef BTB_FWD_EN
        vecs.push_back(mk(1, 1, 32'h180, 32'h600, 1, 32'h140,      0, 0, 32'h144,      1));
`else
        vecs.push_back(mk(1, 1, 32'h180, 32'h600, 1, 32'h140,      1, 1, 32'h500,      1));
`endif
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h140,      0, 0, 32'h144,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h180,      0, 0, 32'h184,      0));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h100,      0, 0, 32'h104,      0));
        // same-cycle update and lookup on an empty entry
`ifdef BTB_FWD_EN
        vecs.push_back(mk(0, 1, 32'h300, 32'h400, 1, 32'h300,      1, 1, 32'h400,      1));
`else
        vecs.push_back(mk(0, 1, 32'h300, 32'h400, 1, 32'h300,      0, 0, 32'h304,      1));
`endif
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,   0, 32'h300,      1, 1, 32'h400,      0));
        vecs.push_back(mk(0, 1, 32'h300, 32'h400, 0, 32'h104,      0, 0, 32'h108,      1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // asynchronous reset mid-cycle while mispredict is high and 0x300 is cached
        bus.upd_valid = 1'b0;
        bus.fetch_PC  = 32'h300;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_mispredict", 100, 32'(bus.mispredict), 32'd0);
        chk("midrst_hit",        100, 32'(bus.hit),        32'd0);
        chk("midrst_pred_PC",    100, bus.pred_PC,         32'h304);
        @(negedge clk);
        rst = 1'b1;
        step(mk(0, 0, 32'h0, 32'h0, 0, 32'h300, 0, 0, 32'h304, 0), 101);
        // counter must be back at WNT: a not-taken miss leaves the table untouched
        step(mk(0, 1, 32'h300, 32'h400, 0, 32'h104, 0, 0, 32'h108, 0), 102);
        step(mk(0, 0, 32'h0, 32'h0, 0, 32'h300, 0, 0, 32'h304, 0), 103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
